key_sw_io_dev: RTL and testbench

//  Memory-mapped input device for KEY[3:0] and SW[9:0], directly downstream of the processor's load/store path.
//  - Synchronises and debounces board inputs.
//  - Exposes DATA/CTRL registers at ADDRKEY/ADDRSW.
//  - Flags changes with ready/overrun status so polling code never misses or double-counts a press.

---
 rtl/key_sw_io_dev_if.sv | 14 +
 rtl/key_sw_io_dev.sv | 180 ++++++++++++++++++
 tb/tb_key_sw_io_dev.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_sw_io_dev_if.sv
// Load/store bus between the processor and the key/switch input device.
interface key_sw_io_dev_if #(
  parameter int unsigned DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic [DBITS-1:0] rdata;
  logic             rsel;

  modport master (output addr, wdata, we, re, input rdata, rsel);
  modport slave  (input addr, wdata, we, re, output rdata, rsel);
endinterface

// File: rtl/key_sw_io_dev.sv
// Memory-mapped KEY/SW input device: synchronise, debounce, DATA/CTRL registers with ready/overrun.
// Define IOIRQ_EN to enable the interrupt output and the ie control bits.
module key_sw_io_deb #(
  parameter int unsigned W         = 4,
  parameter int unsigned DEBCYCLES = 500000
) (
  input  logic         clk,
  input  logic         RESET_N,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] deb_o,
  output logic         chg_o
);
  localparam int unsigned     CW   = $clog2(DEBCYCLES + 1);
  localparam logic [CW-1:0]   CMAX = CW'(DEBCYCLES - 1);

  logic [W-1:0]  s1_q, s2_q, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count only while the synced value is steady and differs from the debounced one.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    chg_o = 1'b0;
    if ((s1_q != s2_q) || (s2_q == deb_q)) begin
      cnt_d = '0;
    end else if (cnt_q >= CMAX) begin
      deb_d = s2_q;
      cnt_d = '0;
      chg_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q  <= '0;
      s2_q  <= '0;
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_o = deb_q;
endmodule

module key_sw_io_dev #(
  parameter int unsigned         DBITS     = 32,
  parameter logic [DBITS-1:0]    ADDRKEY   = 32'hFFFFF080,
  parameter logic [DBITS-1:0]    ADDRSW    = 32'hFFFFF090,
  parameter int unsigned         KEYBITS   = 4,
  parameter int unsigned         SWBITS    = 10,
  parameter int unsigned         DEBCYCLES = 500000
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic [KEYBITS-1:0] KEY,
  input  logic [SWBITS-1:0]  SW,
  key_sw_io_dev_if.slave     bus,
  output logic               irq
);
  logic [KEYBITS-1:0] kdeb;
  logic [SWBITS-1:0]  sdeb;
  logic               kchg, schg;

  key_sw_io_deb #(.W(KEYBITS), .DEBCYCLES(DEBCYCLES)) u_kdeb (
    .clk(clk), .RESET_N(RESET_N), .raw_i(~KEY), .deb_o(kdeb), .chg_o(kchg)
  );
  key_sw_io_deb #(.W(SWBITS), .DEBCYCLES(DEBCYCLES)) u_sdeb (
    .clk(clk), .RESET_N(RESET_N), .raw_i(SW), .deb_o(sdeb), .chg_o(schg)
  );

  logic kdata_hit, kctrl_hit, sdata_hit, sctrl_hit;
  assign kdata_hit = (bus.addr == ADDRKEY);
  assign kctrl_hit = (bus.addr == ADDRKEY + DBITS'(4));
  assign sdata_hit = (bus.addr == ADDRSW);
  assign sctrl_hit = (bus.addr == ADDRSW + DBITS'(4));

  logic kready_q, kready_d, kovr_q, kovr_d, kie_q, kie_d;
  logic sready_q, sready_d, sovr_q, sovr_d, sie_q, sie_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             rsel_q, rsel_d;
  logic             unused_wdata;

  assign unused_wdata = ^bus.wdata;

  function automatic logic [DBITS-1:0] ctrl_word(logic rdy, logic ovr, logic ie);
    ctrl_word    = '0;
    ctrl_word[0] = rdy;
    ctrl_word[1] = ovr;
    ctrl_word[4] = ie;
  endfunction

  // CTRL write is applied first so a same-cycle chg can still force overrun high.
  always_comb begin
    kready_d = kready_q;
    kovr_d   = kovr_q;
    kie_d    = kie_q;
    sready_d = sready_q;
    sovr_d   = sovr_q;
    sie_d    = sie_q;
    if (bus.we && kctrl_hit) begin
      kovr_d = kovr_q & bus.wdata[1];
`ifdef IOIRQ_EN
      kie_d  = bus.wdata[4];
`endif
    end
    if (bus.we && sctrl_hit) begin
      sovr_d = sovr_q & bus.wdata[1];
`ifdef IOIRQ_EN
      sie_d  = bus.wdata[4];
`endif
    end
    if (kchg) begin
      if (kready_q) kovr_d = 1'b1;
      kready_d = 1'b1;
    end else if (bus.re && kdata_hit) begin
      kready_d = 1'b0;
    end
    if (schg) begin
      if (sready_q) sovr_d = 1'b1;
      sready_d = 1'b1;
    end else if (bus.re && sdata_hit) begin
      sready_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    rsel_d  = 1'b0;
    if (bus.re) begin
      rsel_d = kdata_hit | kctrl_hit | sdata_hit | sctrl_hit;
      if (kdata_hit)      rdata_d = DBITS'(kdeb);
      else if (kctrl_hit) rdata_d = ctrl_word(kready_q, kovr_q, kie_q);
      else if (sdata_hit) rdata_d = DBITS'(sdeb);
      else if (sctrl_hit) rdata_d = ctrl_word(sready_q, sovr_q, sie_q);
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      kready_q <= 1'b0;
      kovr_q   <= 1'b0;
      kie_q    <= 1'b0;
      sready_q <= 1'b0;
      sovr_q   <= 1'b0;
      sie_q    <= 1'b0;
      rdata_q  <= '0;
      rsel_q   <= 1'b0;
    end else begin
      kready_q <= kready_d;
      kovr_q   <= kovr_d;
      kie_q    <= kie_d;
      sready_q <= sready_d;
      sovr_q   <= sovr_d;
      sie_q    <= sie_d;
      rdata_q  <= rdata_d;
      rsel_q   <= rsel_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rsel  = rsel_q;

`ifdef IOIRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) irq_q <= 1'b0;
    else          irq_q <= (kready_q & kie_q) | (sready_q & sie_q);
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_key_sw_io_dev.sv
// Randomised bench for key_sw_io_dev with a window-based behavioural model and directed scenarios.
module tb_key_sw_io_dev;
  localparam int          DEB = 4;
  localparam logic [31:0] AK  = 32'hFFFFF080;
  localparam logic [31:0] AS  = 32'hFFFFF090;
  localparam logic [31:0] AU  = 32'hFFFFF088;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = '0;
  logic       irq;

  key_sw_io_dev_if #(.DBITS(32)) bus();

  key_sw_io_dev #(.DEBCYCLES(DEB)) dut (
    .clk(clk), .RESET_N(RESET_N), .KEY(KEY), .SW(SW), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: raw input history (index 0 = most recent edge), debounced values, status bits.
  logic [3:0]  kh [DEB+1];
  logic [9:0]  sh [DEB+1];
  logic [3:0]  m_kdeb;
  logic [9:0]  m_sdeb;
  logic        m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie;
  logic [31:0] m_rdata;
  logic        m_rsel, m_irq;

  task automatic model_reset();
    for (int i = 0; i <= DEB; i++) begin kh[i] = '0; sh[i] = '0; end
    m_kdeb = '0; m_sdeb = '0;
    m_krdy = 0; m_kovr = 0; m_kie = 0; m_srdy = 0; m_sovr = 0; m_sie = 0;
    m_rdata = '0; m_rsel = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] ctrl(logic r, logic o, logic e);
    return {27'd0, e, 2'b00, o, r};
  endfunction

  // A debounced value updates once DEB+1 consecutive raw samples agree and differ from it.
  task automatic model_step();
    bit kc, sc;
    if (!RESET_N) begin model_reset(); return; end
    kc = (kh[0] != m_kdeb);
    sc = (sh[0] != m_sdeb);
    for (int i = 1; i <= DEB; i++) begin
      if (kh[i] != kh[0]) kc = 0;
      if (sh[i] != sh[0]) sc = 0;
    end
    m_rdata = '0; m_rsel = 0;
    if (bus.re) begin
      m_rsel = 1;
      case (bus.addr)
        AK:      m_rdata = {28'd0, m_kdeb};
        AK + 4:  m_rdata = ctrl(m_krdy, m_kovr, m_kie);
        AS:      m_rdata = {22'd0, m_sdeb};
        AS + 4:  m_rdata = ctrl(m_srdy, m_sovr, m_sie);
        default: m_rsel = 0;
      endcase
    end
`ifdef IOIRQ_EN
    m_irq = (m_krdy & m_kie) | (m_srdy & m_sie);
`else
    m_irq = 0;
`endif
    if (bus.we && bus.addr == AK + 4) begin
      m_kovr = m_kovr & bus.wdata[1];
`ifdef IOIRQ_EN
      m_kie = bus.wdata[4];
`endif
    end
    if (bus.we && bus.addr == AS + 4) begin
      m_sovr = m_sovr & bus.wdata[1];
`ifdef IOIRQ_EN
      m_sie = bus.wdata[4];
`endif
    end
    if (kc) begin
      if (m_krdy) m_kovr = 1;
      m_krdy = 1; m_kdeb = kh[0];
    end else if (bus.re && bus.addr == AK) m_krdy = 0;
    if (sc) begin
      if (m_srdy) m_sovr = 1;
      m_srdy = 1; m_sdeb = sh[0];
    end else if (bus.re && bus.addr == AS) m_srdy = 0;
    for (int i = DEB; i > 0; i--) begin kh[i] = kh[i-1]; sh[i] = sh[i-1]; end
    kh[0] = ~KEY;
    sh[0] = SW;
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    cmp("rdata", bus.rdata, m_rdata);
    cmp("rsel", 32'(bus.rsel), 32'(m_rsel));
    cmp("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic rd(logic [31:0] a, output logic [31:0] d);
    bus.re = 1; bus.addr = a;
    tick();
    d = bus.rdata;
    bus.re = 0;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    bus.we = 1; bus.addr = a; bus.wdata = d;
    tick();
    bus.we = 0;
  endtask

  task automatic do_reset();
    #2 RESET_N = 0;
    model_reset();
    #1;
    cmp("async_rst_rdata", bus.rdata, 32'h0);
    cmp("async_rst_rsel", 32'(bus.rsel), 32'h0);
    cmp("async_rst_irq", 32'(irq), 32'h0);
    tick();
    RESET_N = 1;
  endtask

  logic [31:0] d;
  logic [31:0] alist [6];

  initial begin
    bus.addr = '0; bus.wdata = '0; bus.we = 0; bus.re = 0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp("reset_rdata", bus.rdata, 32'h0);
    cmp("reset_rsel", 32'(bus.rsel), 32'h0);
    cmp("reset_irq", 32'(irq), 32'h0);
    RESET_N = 1;

    // Key press debounces, ready set, DATA read clears ready
    KEY = 4'b1110;
    repeat (8) tick();
    rd(AK + 4, d); cmp("t1_kctrl", d, 32'h1);
    rd(AK, d);     cmp("t1_kdata", d, 32'h1);
    rd(AK + 4, d); cmp("t1_kctrl_clr", d, 32'h0);

    // Bouncing switches produce no change until they settle
    for (int i = 0; i < 10; i++) begin SW = ~SW; tick(); tick(); end
    SW = 10'h2A5;
    repeat (10) tick();
    rd(AS + 4, d); cmp("t2_sctrl", d, 32'h1);
    rd(AS, d);     cmp("t2_sdata", d, 32'h2A5);

    // Two changes without a read -> overrun; CTRL write clears only overrun
    KEY = 4'hF;    repeat (8) tick();
    KEY = 4'b1110; repeat (8) tick();
    rd(AK + 4, d); cmp("t3_kctrl_ovr", d, 32'h3);
    wr(AK + 4, 32'h0);
    rd(AK + 4, d); cmp("t3_kctrl_w0", d, 32'h1);
    rd(AK, d);     cmp("t3_kdata", d, 32'h1);
    rd(AK + 4, d); cmp("t3_kctrl_clr", d, 32'h0);

    // chg coincides with a DATA read: set beats clear, read sees the old value
    KEY = 4'hF;
    repeat (5) tick();
    rd(AK, d);     cmp("t4_kdata_old", d, 32'h1);
    rd(AK + 4, d); cmp("t4_kctrl", d, 32'h1);
    rd(AK, d);     cmp("t4_kdata_new", d, 32'h0);

    // Interrupt enable on the switch group
    wr(AS + 4, 32'h10);
    SW = 10'h15A;
    repeat (10) tick();
`ifdef IOIRQ_EN
    cmp("t5_irq_set", 32'(irq), 32'h1);
    rd(AS + 4, d); cmp("t5_sctrl", d, 32'h11);
`else
    cmp("t5_irq_off", 32'(irq), 32'h0);
    rd(AS + 4, d); cmp("t5_sctrl", d, 32'h1);
`endif
    rd(AS, d);     cmp("t5_sdata", d, 32'h15A);
    tick();
    cmp("t5_irq_clr", 32'(irq), 32'h0);

    // Reset with ready set and a key mid-debounce
    SW = 10'h0F0;
    repeat (8) tick();
    KEY = 4'b1011;
    tick(); tick();
    rd(AS, d);     cmp("t6_sdata_pre", d, 32'h0F0);
    do_reset();
    rd(AS, d);     cmp("t6_sdata_rst", d, 32'h0);
    rd(AK + 4, d); cmp("t6_kctrl_rst", d, 32'h0);
    rd(AU, d);     cmp("t6_unmapped_rdata", d, 32'h0);
    cmp("t6_unmapped_rsel", 32'(bus.rsel), 32'h0);

    // Randomised traffic against the model
    alist[0] = AK; alist[1] = AK + 4; alist[2] = AS; alist[3] = AS + 4; alist[4] = AU;
    for (int c = 0; c < 3000; c++) begin
      alist[5] = $urandom;
      if ($urandom_range(0, 11) == 0) KEY = 4'($urandom);
      if ($urandom_range(0, 11) == 0) SW = 10'($urandom);
      bus.re = 0; bus.we = 0;
      bus.addr = alist[$urandom_range(0, 5)];
      bus.wdata = $urandom;
      case ($urandom_range(0, 7))
        0, 1, 2: bus.re = 1;
        3:       bus.we = 1;
        4:       begin bus.re = 1; bus.we = 1; end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) bus.addr = bus.re ? AK + 4 : AS + 4;
      if ($urandom_range(0, 599) == 0) begin
        bus.re = 0; bus.we = 0;
        do_reset();
      end else begin
        tick();
      end
    end
    bus.re = 0; bus.we = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
